// File: rtl/contador_pkg.sv
// Shared definitions for the contador arbiter slice.
// Mode encodings, FSM states and default widths.
package contador_pkg;

  localparam int DEF_W = 4;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UP3  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with last-served pointer.
// req in, pick/any out; upd/upd_id record the served side.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       pick,
  output logic       any
);

  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (upd) last_d = upd_id;
  end

  always_comb begin
    any  = |req;
    pick = 1'b0;
    case (req)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_q;
      default: pick = 1'b0;
    endcase
  end

  // Reset as "1 served last" so requester 0 wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/contador_arb.sv
// Shares one 4-bit contador between two job requesters.
// req/modo/D/len in, gnt/done/res out, enable/modo/D/Q/rco to counter.
module contador_arb
  import contador_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          req0,
  input  logic [1:0]    modo0,
  input  logic [W-1:0]  D0,
  input  logic [W-1:0]  len0,
  input  logic          req1,
  input  logic [1:0]    modo1,
  input  logic [W-1:0]  D1,
  input  logic [W-1:0]  len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [W-1:0]  res_q,
  output logic [CW-1:0] res_wraps,
  output logic          enable,
  output logic [1:0]    modo,
  output logic [W-1:0]  D,
  input  logic [W-1:0]  Q,
  input  logic          rco
);

  state_t        state_q, state_d;
  logic          own_q, own_d;
  logic [1:0]    modo_q, modo_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  len_q, len_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] wr_q, wr_d;
  logic [CW-1:0] wr_inc;
  logic          pick, any;
  logic [1:0]    p_modo;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (reset_L),
    .req    ({req1, req0}),
    .upd    (state_q == DONE),
    .upd_id (own_q),
    .pick   (pick),
    .any    (any)
  );

  assign p_modo = pick ? modo1 : modo0;
  assign gnt0 = (state_q != IDLE) & ~own_q;
  assign gnt1 = (state_q != IDLE) & own_q;

  always_comb begin
    wr_inc = wr_q;
    if (rco && (wr_q != '1)) wr_inc = wr_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    modo_d    = modo_q;
    d_d       = d_q;
    len_d     = len_q;
    rem_d     = rem_q;
    wr_d      = wr_q;
    enable    = 1'b0;
    modo      = 2'b00;
    D         = '0;
    done0     = 1'b0;
    done1     = 1'b0;
    res_q     = '0;
    res_wraps = '0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          own_d   = pick;
          modo_d  = p_modo;
          d_d     = pick ? D1 : D0;
          len_d   = pick ? len1 : len0;
          if (p_modo == MODE_LOAD) len_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        enable  = 1'b1;
        modo    = MODE_LOAD;
        D       = d_q;
        rem_d   = len_q;
        wr_d    = '0;
        state_d = (len_q != '0) ? RUN : DONE;
      end
      RUN: begin
        enable = 1'b1;
        modo   = modo_q;
        D      = d_q;
        rem_d  = rem_q - 1'b1;
        // First RUN cycle still shows the load result.
        if (rem_q != len_q) wr_d = wr_inc;
        if (rem_q == W'(1)) state_d = DONE;
      end
      DONE: begin
        done0     = ~own_q;
        done1     = own_q;
        res_q     = Q;
        res_wraps = wr_inc;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      modo_q  <= 2'b00;
      d_q     <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      modo_q  <= modo_d;
      d_q     <= d_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      wr_q    <= wr_d;
    end
  end

endmodule
